spi_cmd_controller: RTL and testbench

SPI_CMD_CONTROLLER -- requirements
Module: spi_cmd_controller

---
 rtl/spi_cmd_controller.sv | 217 +++++++++++++++++++++
 tb/tb_spi_cmd_controller.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_controller.sv
// Byte-level command decoder between the SPI slave front end and the 64x64 matrix memory / transformer core.
// Handles framed WRITE/READ bursts, START and STATUS; all outputs are registered.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for an opcode byte
// HDR_AH   | waiting for address high byte (low nibble used)
// HDR_AL   | waiting for address low byte
// HDR_LEN  | waiting for length byte (words = L+1)
// WR_HI    | waiting for write data [15:8]
// WR_LO    | waiting for write data [7:0]; issues the memory write
// RD_FETCH | memory read strobe in flight
// RD_HI    | read data landing, high byte sent; waiting for dummy byte
// RD_LO    | low byte sent; waiting for dummy byte before next fetch
// DRAIN    | bad opcode seen, ignoring bytes until chip-select drops
module spi_cmd_controller (
   input  logic        clk,
   input  logic        rst,
   input  logic        cs_active,
   input  logic [7:0]  rx_byte,
   input  logic        rx_valid,
   output logic [7:0]  tx_byte,
   output logic        tx_valid,
   output logic        mem_we,
   output logic        mem_re,
   output logic [11:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   output logic        core_start,
   input  logic        core_busy,
   input  logic        core_done,
   output logic        err
);

   localparam logic [7:0] OP_WRITE  = 8'hA1;
   localparam logic [7:0] OP_START  = 8'hA2;
   localparam logic [7:0] OP_STATUS = 8'hA3;
   localparam logic [7:0] OP_READ   = 8'hA4;

   typedef enum logic [3:0] {
      IDLE, HDR_AH, HDR_AL, HDR_LEN, WR_HI, WR_LO, RD_FETCH, RD_HI, RD_LO, DRAIN
   } state_t;

   state_t      state, state_nxt;
   logic        is_read, is_read_nxt;
   logic [11:0] addr, addr_nxt;
   logic [7:0]  count, count_nxt;
   logic [7:0]  data_hi, data_hi_nxt;
   logic [15:0] word, word_nxt;
   logic        rd_wait, rd_wait_nxt;
   logic        done_sticky, done_sticky_nxt;
   logic        status_clr;

   logic [7:0]  tx_byte_nxt;
   logic        tx_valid_nxt, mem_we_nxt, mem_re_nxt, core_start_nxt, err_nxt;
   logic [11:0] mem_addr_nxt;
   logic [15:0] mem_wdata_nxt;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      is_read_nxt    = is_read;
      addr_nxt       = addr;
      count_nxt      = count;
      data_hi_nxt    = data_hi;
      word_nxt       = word;
      rd_wait_nxt    = 1'b0;
      status_clr     = 1'b0;
      tx_byte_nxt    = tx_byte;
      tx_valid_nxt   = 1'b0;
      mem_we_nxt     = 1'b0;
      mem_re_nxt     = 1'b0;
      mem_addr_nxt   = mem_addr;
      mem_wdata_nxt  = mem_wdata;
      core_start_nxt = 1'b0;
      err_nxt        = err;

      // Chip-select loss overrides everything, including a byte arriving in the same cycle.
      if (!cs_active) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: if (rx_valid) begin
               case (rx_byte)
                  OP_WRITE: begin
                     is_read_nxt = 1'b0;
                     state_nxt   = HDR_AH;
                  end
                  OP_READ: begin
                     is_read_nxt = 1'b1;
                     state_nxt   = HDR_AH;
                  end
                  OP_START: begin
                     if (core_busy) err_nxt        = 1'b1;
                     else           core_start_nxt = 1'b1;
                  end
                  OP_STATUS: begin
                     tx_valid_nxt = 1'b1;
                     tx_byte_nxt  = {5'b0, err, done_sticky, core_busy};
                     status_clr   = 1'b1;
                  end
                  default: begin
                     err_nxt   = 1'b1;
                     state_nxt = DRAIN;
                  end
               endcase
            end
            HDR_AH: if (rx_valid) begin
               addr_nxt  = {rx_byte[3:0], addr[7:0]};
               state_nxt = HDR_AL;
            end
            HDR_AL: if (rx_valid) begin
               addr_nxt  = {addr[11:8], rx_byte};
               state_nxt = HDR_LEN;
            end
            HDR_LEN: if (rx_valid) begin
               count_nxt = rx_byte;
               if (is_read) begin
                  mem_re_nxt   = 1'b1;
                  mem_addr_nxt = addr;
                  state_nxt    = RD_FETCH;
               end else begin
                  state_nxt = WR_HI;
               end
            end
            WR_HI: if (rx_valid) begin
               data_hi_nxt = rx_byte;
               state_nxt   = WR_LO;
            end
            WR_LO: if (rx_valid) begin
               mem_we_nxt    = 1'b1;
               mem_addr_nxt  = addr;
               mem_wdata_nxt = {data_hi, rx_byte};
               addr_nxt      = addr + 12'd1;
               if (count == 8'd0) begin
                  state_nxt = IDLE;
               end else begin
                  count_nxt = count - 8'd1;
                  state_nxt = WR_HI;
               end
            end
            RD_FETCH: begin
               rd_wait_nxt = 1'b1;
               state_nxt   = RD_HI;
            end
            RD_HI: begin
               // First cycle here is when mem_rdata is valid; dummy bytes are only honoured after that.
               if (rd_wait) begin
                  word_nxt     = mem_rdata;
                  tx_byte_nxt  = mem_rdata[15:8];
                  tx_valid_nxt = 1'b1;
               end else if (rx_valid) begin
                  tx_byte_nxt  = word[7:0];
                  tx_valid_nxt = 1'b1;
                  state_nxt    = RD_LO;
               end
            end
            RD_LO: if (rx_valid) begin
               if (count == 8'd0) begin
                  state_nxt = IDLE;
               end else begin
                  count_nxt    = count - 8'd1;
                  addr_nxt     = addr + 12'd1;
                  mem_re_nxt   = 1'b1;
                  mem_addr_nxt = addr + 12'd1;
                  state_nxt    = RD_FETCH;
               end
            end
            DRAIN: state_nxt = DRAIN;
            default: state_nxt = IDLE;
         endcase
      end

      done_sticky_nxt = core_done | (done_sticky & ~status_clr);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         is_read     <= 1'b0;
         addr        <= '0;
         count       <= '0;
         data_hi     <= '0;
         word        <= '0;
         rd_wait     <= 1'b0;
         done_sticky <= 1'b0;
         tx_byte     <= '0;
         tx_valid    <= 1'b0;
         mem_we      <= 1'b0;
         mem_re      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         core_start  <= 1'b0;
         err         <= 1'b0;
      end else begin
         is_read     <= is_read_nxt;
         addr        <= addr_nxt;
         count       <= count_nxt;
         data_hi     <= data_hi_nxt;
         word        <= word_nxt;
         rd_wait     <= rd_wait_nxt;
         done_sticky <= done_sticky_nxt;
         tx_byte     <= tx_byte_nxt;
         tx_valid    <= tx_valid_nxt;
         mem_we      <= mem_we_nxt;
         mem_re      <= mem_re_nxt;
         mem_addr    <= mem_addr_nxt;
         mem_wdata   <= mem_wdata_nxt;
         core_start  <= core_start_nxt;
         err         <= err_nxt;
      end
   end

endmodule

// File: tb/tb_spi_cmd_controller.sv
// Directed bench for spi_cmd_controller: a behavioural matrix memory plus
// scoreboard queues for memory writes, read strobes and transmitted bytes.
module tb_spi_cmd_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        cs_active;
   logic [7:0]  rx_byte;
   logic        rx_valid;
   logic [7:0]  tx_byte;
   logic        tx_valid;
   logic        mem_we;
   logic        mem_re;
   logic [11:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        core_start;
   logic        core_busy;
   logic        core_done;
   logic        err;

   always #5 clk = ~clk;

   spi_cmd_controller dut (
      .clk        (clk),
      .rst        (rst),
      .cs_active  (cs_active),
      .rx_byte    (rx_byte),
      .rx_valid   (rx_valid),
      .tx_byte    (tx_byte),
      .tx_valid   (tx_valid),
      .mem_we     (mem_we),
      .mem_re     (mem_re),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .core_start (core_start),
      .core_busy  (core_busy),
      .core_done  (core_done),
      .err        (err)
   );

   typedef struct {
      logic [11:0] a;
      logic [15:0] d;
   } wr_t;

   wr_t         exp_wr[$];
   logic [11:0] exp_re[$];
   logic [7:0]  exp_tx[$];
   wr_t         mon_w;
   logic [11:0] mon_a;
   logic [7:0]  mon_b;

   int checks = 0;
   int errors = 0;
   int wr_cnt = 0;
   int start_cnt = 0;
   logic m_err = 1'b0;
   logic m_done = 1'b0;

   logic [15:0] mem [0:4095];

   // Single-port memory with one-cycle read latency.
   always @(posedge clk) begin
      if (mem_re) mem_rdata <= mem[mem_addr];
      if (mem_we) mem[mem_addr] <= mem_wdata;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (mem_we || mem_re) check("we_re_exclusive", {31'b0, mem_we & mem_re}, 32'd0);
         if (mem_we) begin
            wr_cnt++;
            if (exp_wr.size() == 0) begin
               check("mem_we_unexpected", {31'b0, mem_we}, 32'd0);
            end else begin
               mon_w = exp_wr.pop_front();
               check("wr_addr", {20'b0, mem_addr}, {20'b0, mon_w.a});
               check("wr_data", {16'b0, mem_wdata}, {16'b0, mon_w.d});
            end
         end
         if (mem_re) begin
            if (exp_re.size() == 0) begin
               check("mem_re_unexpected", {31'b0, mem_re}, 32'd0);
            end else begin
               mon_a = exp_re.pop_front();
               check("rd_addr", {20'b0, mem_addr}, {20'b0, mon_a});
            end
         end
         if (tx_valid) begin
            if (exp_tx.size() == 0) begin
               check("tx_unexpected", {31'b0, tx_valid}, 32'd0);
            end else begin
               mon_b = exp_tx.pop_front();
               check("tx_byte", {24'b0, tx_byte}, {24'b0, mon_b});
            end
         end
         if (core_start) start_cnt++;
      end
   end

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_byte  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic push_wr(input logic [11:0] a, input logic [15:0] d);
      wr_t w;
      w.a = a;
      w.d = d;
      exp_wr.push_back(w);
   endtask

   task automatic status_cmd();
      exp_tx.push_back({5'b0, m_err, m_done, core_busy});
      send(8'hA3);
      m_done = 1'b0;
   endtask

   task automatic pulse_done();
      @(negedge clk);
      core_done = 1'b1;
      @(negedge clk);
      core_done = 1'b0;
      m_done    = 1'b1;
   endtask

   initial begin
      rst       = 1'b1;
      cs_active = 1'b0;
      rx_valid  = 1'b0;
      rx_byte   = 8'h00;
      core_busy = 1'b0;
      core_done = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tx_byte",    {24'b0, tx_byte},   32'd0);
      check("rst_tx_valid",   {31'b0, tx_valid},  32'd0);
      check("rst_mem_we",     {31'b0, mem_we},    32'd0);
      check("rst_mem_re",     {31'b0, mem_re},    32'd0);
      check("rst_mem_addr",   {20'b0, mem_addr},  32'd0);
      check("rst_mem_wdata",  {16'b0, mem_wdata}, 32'd0);
      check("rst_core_start", {31'b0, core_start}, 32'd0);
      check("rst_err",        {31'b0, err},       32'd0);
      rst       = 1'b0;
      cs_active = 1'b1;
      repeat (2) @(negedge clk);

      // Writes: single word, preload for the read, upper address nibble ignored, wrap.
      push_wr(12'h010, 16'h1234);
      send(8'hA1); send(8'h00); send(8'h10); send(8'h00); send(8'h12); send(8'h34);
      push_wr(12'h005, 16'hBEEF);
      send(8'hA1); send(8'h00); send(8'h05); send(8'h00); send(8'hBE); send(8'hEF);
      push_wr(12'h020, 16'h0007);
      send(8'hA1); send(8'h50); send(8'h20); send(8'h00); send(8'h00); send(8'h07);
      push_wr(12'hFFF, 16'hAABB);
      push_wr(12'h000, 16'hCCDD);
      send(8'hA1); send(8'h0F); send(8'hFF); send(8'h01);
      send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
      check("write_count", wr_cnt, 32'd5);

      // Single-word read, then STATUS proves the FSM is back in IDLE.
      exp_re.push_back(12'h005);
      exp_tx.push_back(8'hBE);
      exp_tx.push_back(8'hEF);
      send(8'hA4); send(8'h00); send(8'h05); send(8'h00);
      send(8'h00);
      send(8'h00);
      status_cmd();

      // Two-word read across the wrap.
      exp_re.push_back(12'hFFF);
      exp_re.push_back(12'h000);
      exp_tx.push_back(8'hAA); exp_tx.push_back(8'hBB);
      exp_tx.push_back(8'hCC); exp_tx.push_back(8'hDD);
      send(8'hA4); send(8'h0F); send(8'hFF); send(8'h01);
      repeat (4) send(8'h00);
      status_cmd();

      // Abort: CS drops together with the final data byte; bytes with CS low are ignored.
      send(8'hA1); send(8'h00); send(8'h00); send(8'h00); send(8'h12);
      @(negedge clk);
      rx_byte   = 8'h34;
      rx_valid  = 1'b1;
      cs_active = 1'b0;
      @(negedge clk);
      rx_valid = 1'b0;
      send(8'hA3);
      cs_active = 1'b1;
      repeat (2) @(negedge clk);
      push_wr(12'h030, 16'h5678);
      send(8'hA1); send(8'h00); send(8'h30); send(8'h00); send(8'h56); send(8'h78);
      check("write_count_abort", wr_cnt, 32'd6);
      check("err_after_abort", {31'b0, err}, 32'd0);

      // START while idle core, done reporting and clear.
      core_busy = 1'b0;
      send(8'hA2);
      check("start_pulse", start_cnt, 32'd1);
      pulse_done();
      status_cmd();
      status_cmd();

      // core_done landing on the STATUS clear keeps done_sticky set.
      exp_tx.push_back({5'b0, m_err, 1'b0, core_busy});
      @(negedge clk);
      rx_byte   = 8'hA3;
      rx_valid  = 1'b1;
      core_done = 1'b1;
      @(negedge clk);
      rx_valid  = 1'b0;
      core_done = 1'b0;
      repeat (4) @(negedge clk);
      m_done = 1'b1;
      status_cmd();
      check("err_before_bad_op", {31'b0, err}, 32'd0);

      // Bad opcode: err sets, following bytes ignored until CS drops.
      send(8'h55);
      m_err = 1'b1;
      check("err_bad_op", {31'b0, err}, 32'd1);
      send(8'hA3); send(8'hA1); send(8'hA2);
      check("drain_no_start", start_cnt, 32'd1);
      @(negedge clk);
      cs_active = 1'b0;
      repeat (2) @(negedge clk);
      cs_active = 1'b1;
      repeat (2) @(negedge clk);
      status_cmd();

      // START while busy: no pulse, err stays set; STATUS reads 0x05.
      core_busy = 1'b1;
      send(8'hA2);
      check("busy_no_start", start_cnt, 32'd1);
      check("err_busy_start", {31'b0, err}, 32'd1);
      exp_tx.push_back(8'h05);
      send(8'hA3);
      core_busy = 1'b0;

      // Reset in the middle of a write, coinciding with the last data byte.
      pulse_done();
      send(8'hA1); send(8'h00); send(8'h40); send(8'h00); send(8'h11);
      @(negedge clk);
      rx_byte  = 8'h22;
      rx_valid = 1'b1;
      rst      = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      check("rst_mid_err", {31'b0, err}, 32'd0);
      check("rst_mid_we", {31'b0, mem_we}, 32'd0);
      rst    = 1'b0;
      m_err  = 1'b0;
      m_done = 1'b0;
      status_cmd();
      push_wr(12'h040, 16'h2233);
      send(8'hA1); send(8'h00); send(8'h40); send(8'h00); send(8'h22); send(8'h33);
      check("write_count_final", wr_cnt, 32'd7);

      for (int i = 0; i < 200 && (exp_wr.size() + exp_re.size() + exp_tx.size()) != 0; i++)
         @(negedge clk);
      check("pending_writes", exp_wr.size(), 32'd0);
      check("pending_reads", exp_re.size(), 32'd0);
      check("pending_tx", exp_tx.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
